// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues word reads to instruction memory and presents the
// returned words in program order to decode. A redirect flushes buffered words and marks
// every outstanding response for discard.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imemReqValid,
   output logic [31:0] imemReqAddr,
   input  logic        imemReqReady,
   input  logic        imemRespValid,
   input  logic [31:0] imemRespData,
   output logic        outValid,
   output logic [31:0] outInstr,
   output logic [31:0] outPC,
   output logic [5:0]  outOpcode,
   input  logic        inReady,
   input  logic        redirectValid,
   input  logic [31:0] redirectPC
);

   localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_d;
   logic [31:0]   r_pc;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_fifo_cnt;
   logic [CW-1:0] r_drop_cnt;
   logic [CW-1:0] w_drop_d;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_tag_wr_ptr;
   logic [AW-1:0] r_tag_rd_ptr;
   logic [31:0]   r_fifo_instr [BUF_DEPTH];
   logic [31:0]   r_fifo_pc    [BUF_DEPTH];
   logic [31:0]   r_tag_pc     [BUF_DEPTH];

   logic          w_active;
   logic          w_pop;
   logic [CW:0]   w_occ;
   logic          w_req_valid;
   logic          w_fire;
   logic          w_resp;
   logic          w_drop;
   logic          w_push;
   logic          w_unused_redirect_lsbs;

   assign w_unused_redirect_lsbs = ^redirectPC[1:0];

   // Handshakes, occupancy and next drop count / state.
   always_comb begin
      w_active = (r_state != ST_BOOT);
      outValid = (r_fifo_cnt != '0);
      w_pop    = outValid & inReady;
      // A pop this cycle frees a slot, which keeps single-cycle memory at full rate.
      w_occ       = {1'b0, r_inflight} + {1'b0, r_fifo_cnt} - {{CW{1'b0}}, w_pop};
      w_req_valid = w_active && (w_occ < DEPTH_C);
      w_fire      = w_req_valid & imemReqReady;
      // A response with nothing outstanding is a protocol error and is ignored.
      w_resp = imemRespValid && (r_inflight != '0);
      w_drop = w_resp && (redirectValid || (r_drop_cnt != '0));
      w_push = w_resp && !w_drop;

      w_drop_d = r_drop_cnt;
      if (redirectValid) begin
         w_drop_d = r_inflight + CW'(w_fire) - CW'(w_resp);
      end else if (w_drop) begin
         w_drop_d = r_drop_cnt - CW'(1);
      end

      w_state_d = ST_RUN;
      if (r_state != ST_BOOT && w_drop_d != '0) begin
         w_state_d = ST_DRAIN;
      end
   end

   // Output presentation; head fields read as zero while the buffer is empty.
   always_comb begin
      imemReqValid = w_req_valid;
      imemReqAddr  = r_pc;
      outInstr     = '0;
      outPC        = '0;
      if (outValid) begin
         outInstr = r_fifo_instr[r_rd_ptr];
         outPC    = r_fifo_pc[r_rd_ptr];
      end
      outOpcode = outInstr[31:26];
   end

   // Control state: PC, counters, pointers and FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_PC;
         r_inflight   <= '0;
         r_fifo_cnt   <= '0;
         r_drop_cnt   <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_tag_wr_ptr <= '0;
         r_tag_rd_ptr <= '0;
      end else begin
         r_state      <= w_state_d;
         r_drop_cnt   <= w_drop_d;
         r_inflight   <= r_inflight + CW'(w_fire) - CW'(w_resp);
         r_tag_wr_ptr <= r_tag_wr_ptr + AW'(w_fire);
         r_tag_rd_ptr <= r_tag_rd_ptr + AW'(w_resp);
         r_wr_ptr     <= r_wr_ptr + AW'(w_push);
         if (redirectValid) begin
            r_pc       <= {redirectPC[31:2], 2'b00};
            r_rd_ptr   <= r_wr_ptr;
            r_fifo_cnt <= '0;
         end else begin
            if (w_fire) begin
               r_pc <= r_pc + 32'd4;
            end
            r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
            r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   // Storage: PC tags written at issue, words written with their tag on response.
   always_ff @(posedge clk) begin
      if (w_fire) begin
         r_tag_pc[r_tag_wr_ptr] <= r_pc;
      end
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= imemRespData;
         r_fifo_pc[r_wr_ptr]    <= r_tag_pc[r_tag_rd_ptr];
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model plus a latency-configurable memory.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int unsigned BUF_DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        imemReqValid;
   logic [31:0] imemReqAddr;
   logic        imemReqReady;
   logic        imemRespValid;
   logic [31:0] imemRespData;
   logic        outValid;
   logic [31:0] outInstr;
   logic [31:0] outPC;
   logic [5:0]  outOpcode;
   logic        inReady;
   logic        redirectValid;
   logic [31:0] redirectPC;

   instr_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imemReqValid  (imemReqValid),
      .imemReqAddr   (imemReqAddr),
      .imemReqReady  (imemReqReady),
      .imemRespValid (imemRespValid),
      .imemRespData  (imemRespData),
      .outValid      (outValid),
      .outInstr      (outInstr),
      .outPC         (outPC),
      .outOpcode     (outOpcode),
      .inReady       (inReady),
      .redirectValid (redirectValid),
      .redirectPC    (redirectPC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int lat      = 1;

   // Reference model: outstanding request PCs, buffered PCs, pending discards, next fetch PC.
   logic [31:0] out_q [$];
   logic [31:0] buf_q [$];
   int          drop_n = 0;
   logic [31:0] exp_req = RESET_PC;
   // Memory model: accepted addresses and the cycle each response becomes available.
   logic [31:0] mem_addr [$];
   int          mem_rdy  [$];
   // DUT-observed logs for directed checks.
   logic [31:0] fire_log [$];
   logic [31:0] pop_log  [$];

   bit          was_rst   = 1'b0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_addr = '0;
   logic        last_out_valid;
   logic [31:0] last_out_pc;
   logic        last_req_valid;
   logic [31:0] last_req_addr;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[7:2] ^ 6'h15, a[27:2] ^ 26'h2ABCDEF};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_tmo(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out, got no progress, expected progress (cycle %0d)", name, cyc);
   endtask

   task automatic clear_logs();
      fire_log.delete();
      pop_log.delete();
   endtask

   // Compare DUT against the model, then advance the model by this cycle's events.
   task automatic evaluate(input bit r);
      bit          exp_valid;
      bit          pop;
      bit          fire;
      int          occ;
      logic [31:0] w;
      logic [31:0] pc;
      last_out_valid = outValid;
      last_out_pc    = outPC;
      last_req_valid = imemReqValid;
      last_req_addr  = imemReqAddr;
      if (r) begin
         out_q.delete();
         buf_q.delete();
         mem_addr.delete();
         mem_rdy.delete();
         drop_n    = 0;
         exp_req   = RESET_PC;
         prev_hold = 1'b0;
         was_rst   = 1'b1;
         return;
      end
      if (was_rst) begin
         chk("reset_out_valid", {31'b0, outValid}, 32'd0);
         chk("reset_req_valid", {31'b0, imemReqValid}, 32'd0);
         chk("reset_req_addr", imemReqAddr, RESET_PC);
         chk("reset_out_instr", outInstr, 32'd0);
         chk("reset_out_pc", outPC, 32'd0);
         was_rst = 1'b0;
      end
      exp_valid = (buf_q.size() > 0);
      chk("out_valid", {31'b0, outValid}, {31'b0, exp_valid});
      if (exp_valid) begin
         w = instr_of(buf_q[0]);
         chk("out_pc", outPC, buf_q[0]);
         chk("out_instr", outInstr, w);
         chk("out_opcode", {26'b0, outOpcode}, {26'b0, w[31:26]});
      end
      if (prev_hold) begin
         chk("req_held_valid", {31'b0, imemReqValid}, 32'd1);
         chk("req_held_addr", imemReqAddr, prev_addr);
      end
      pop  = exp_valid && inReady;
      fire = imemReqValid && imemReqReady;
      if (imemReqValid) begin
         occ = out_q.size() + buf_q.size() - (pop ? 1 : 0);
         chk("req_addr", imemReqAddr, exp_req);
         chk("capacity", {31'b0, occ < BUF_DEPTH}, 32'd1);
      end
      if (outValid && inReady) pop_log.push_back(outPC);
      if (fire) begin
         fire_log.push_back(imemReqAddr);
         out_q.push_back(exp_req);
         mem_addr.push_back(exp_req);
         mem_rdy.push_back(cyc + lat);
         exp_req = exp_req + 32'd4;
      end
      if (pop) void'(buf_q.pop_front());
      if (imemRespValid) begin
         if (out_q.size() == 0) begin
            fail_tmo("resp_bookkeeping");
         end else begin
            pc = out_q.pop_front();
            if (!redirectValid) begin
               if (drop_n > 0) drop_n--;
               else buf_q.push_back(pc);
            end
         end
      end
      if (redirectValid) begin
         buf_q.delete();
         drop_n  = out_q.size();
         exp_req = {redirectPC[31:2], 2'b00};
      end
      prev_hold = imemReqValid && !imemReqReady && !redirectValid;
      prev_addr = imemReqAddr;
   endtask

   // One clock: drive inputs after the rising edge, check at the falling edge.
   task automatic cycle(input bit r, input bit rdy, input bit ir, input bit rv,
                        input logic [31:0] rt);
      rst           = r;
      imemReqReady  = rdy;
      inReady       = ir;
      redirectValid = rv;
      redirectPC    = rt;
      if (!r && mem_addr.size() > 0 && mem_rdy[0] <= cyc) begin
         imemRespValid = 1'b1;
         imemRespData  = instr_of(mem_addr[0]);
         void'(mem_addr.pop_front());
         void'(mem_rdy.pop_front());
      end else begin
         imemRespValid = 1'b0;
         imemRespData  = $urandom;
      end
      @(negedge clk);
      evaluate(r);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      clear_logs();
   endtask

   initial begin
      bit done;
      bit ir;
      int pops;
      rst           = 1'b1;
      imemReqReady  = 1'b0;
      imemRespValid = 1'b0;
      imemRespData  = '0;
      inReady       = 1'b0;
      redirectValid = 1'b0;
      redirectPC    = '0;

      // Reset release with single-cycle memory: first word 3 cycles later, then no bubbles.
      lat = 1;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
         if (k == 1) begin
            chk("t1_first_req_valid", {31'b0, last_req_valid}, 32'd1);
            chk("t1_first_req_addr", last_req_addr, RESET_PC);
         end
         if (k == 2) chk("t1_no_early_out", {31'b0, last_out_valid}, 32'd0);
         if (k >= 3) begin
            chk("t1_no_bubble", {31'b0, last_out_valid}, 32'd1);
            chk("t1_out_pc", last_out_pc, RESET_PC + 32'(4 * (k - 3)));
         end
      end

      // Decode stall: requests stop once the buffer is full, stream resumes intact.
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      chk("t2_req_stalled", {31'b0, last_req_valid}, 32'd0);
      chk("t2_out_held", {31'b0, last_out_valid}, 32'd1);
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      chk("t2_pop_count", {31'b0, pop_log.size() >= 15}, 32'd1);
      for (int i = 0; i < pop_log.size(); i++) begin
         chk("t2_order", pop_log[i], RESET_PC + 32'(4 * i));
      end

      // Redirect with two requests in flight and 3-cycle memory.
      lat = 3;
      do_reset();
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_q.size() == 2 && buf_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      end
      if (!done) fail_tmo("t3_setup");
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
      clear_logs();
      done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (pop_log.size() > 0) begin
            done = 1'b1;
            break;
         end
         cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      end
      if (!done || fire_log.size() == 0) fail_tmo("t3_after_redirect");
      else begin
         chk("t3_next_req", fire_log[0], 32'h0000_0100);
         chk("t3_next_out", pop_log[0], 32'h0000_0100);
      end

      // Redirect coinciding with consumption of 0x10 while 0x14 is buffered.
      lat = 1;
      do_reset();
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (buf_q.size() == 2 && buf_q[0] == 32'h10) begin
            done = 1'b1;
            break;
         end
         ir = (buf_q.size() > 0) && (buf_q[0] < 32'h10);
         cycle(1'b0, 1'b1, ir, 1'b0, 32'd0);
      end
      if (!done) fail_tmo("t4_setup");
      clear_logs();
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (pop_log.size() >= 2) begin
            done = 1'b1;
            break;
         end
         cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      end
      if (!done) fail_tmo("t4_after_redirect");
      else begin
         chk("t4_delay_slot", pop_log[0], 32'h10);
         chk("t4_target", pop_log[1], 32'h200);
      end

      // Randomized traffic: toggling ready, 1..3 cycle latency, random stalls and redirects.
      for (int l = 1; l <= 3; l++) begin
         lat = l;
         do_reset();
         for (int k = 0; k < 250; k++) begin
            cycle(1'b0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 49) == 0, $urandom);
         end
         pops = pop_log.size();
         chk("t5_progress", {31'b0, pops > 10}, 32'd1);
      end

      // PC wrap at the top of the address space, then reset mid-stream.
      lat = 1;
      do_reset();
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      clear_logs();
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (fire_log.size() >= 3 && pop_log.size() >= 3) begin
            done = 1'b1;
            break;
         end
         cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      end
      if (!done) fail_tmo("t6_wrap");
      else begin
         chk("t6_req0", fire_log[0], 32'hFFFF_FFF8);
         chk("t6_req1", fire_log[1], 32'hFFFF_FFFC);
         chk("t6_req2", fire_log[2], 32'h0000_0000);
         chk("t6_out2", pop_log[2], 32'h0000_0000);
      end
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      clear_logs();
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      chk("t6_out_after_rst", {31'b0, last_out_valid}, 32'd0);
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (fire_log.size() > 0) begin
            done = 1'b1;
            break;
         end
         cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      end
      if (!done) fail_tmo("t6_restart");
      else chk("t6_restart_addr", fire_log[0], RESET_PC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
